branch_backup_fifo: RTL and testbench
=====================================

Name: branch_backup_fifo

Overview:
- Parametrised successor of the 11-bit branch backup FIFO in the branch-prediction path of the MicroEV20 core.
- Each predicted branch pushes the PC of the non-predicted path, selected from two candidate buses. On a misprediction, the recovery logic pops that PC.
- Generalised in width and depth. Adds occupancy count, full/empty flags, sticky error flags, head peek and a synchronous flush.
- Sits between the fetch/branch_predictor and the PC-recovery mux.

Parameters:
- WIDTH, 11: bit width of each stored PC.
- DEPTH, 4: number of entries. Must be a power of two and at least 2.
- CNT_W, $clog2(DEPTH)+1: width of the occupancy count.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- clear  in  1  synchronous flush; empties the FIFO
- enable  in  1  1: honour select; 0: push source is forced to I1
- select  in  1  when enable=1: 1 pushes I1, 0 pushes I2
- push  in  1  write the selected input at the posedge
- pop  in  1  read the head entry at the posedge
- I1  in  WIDTH  default push source
- I2  in  WIDTH  alternate push source
- P  out  WIDTH  registered pop data
- head  out  WIDTH  combinational peek of the oldest entry
- count  out  CNT_W  number of valid entries
- empty  out  1  count==0
- full  out  1  count==DEPTH
- overflow  out  1  sticky: a push was dropped
- underflow  out  1  sticky: a pop was issued while empty

Behaviour:
- Input selection is continuous: curr = (enable && !select) ? I2 : I1. It is sampled only at the posedge when push=1.
- Reset (async, reset=1):
  - read/write pointers and count reset to 0.
  - P, overflow and underflow reset to 0.
  - empty=1, full=0, head=0.
  - Storage contents are don't-care, but head must read 0 when empty.
- Operation priority at each posedge: reset > clear > push/pop.
- clear=1:
  - pointers and count go to 0; P goes to 0.
  - overflow and underflow are also cleared.
  - push and pop in the same cycle are ignored.
- Pop, not empty: P <= mem[rptr] at the posedge. The value is visible in the cycle after the edge (latency 1). rptr advances and count decrements.
- Pop, empty: P holds its value, count stays 0, underflow <= 1.
- Push, not full: mem[wptr] <= curr, wptr advances, count increments.
- Push, full, no pop: the data is dropped, state is unchanged, overflow <= 1.
- Push and pop together, not empty: both take effect.
  - count is unchanged.
  - When full, the push is accepted because the pop frees a slot. No overflow.
- Push and pop together, empty: the push is accepted and the pop is treated as underflow.
  - P holds its value; no bypass.
  - count becomes 1, underflow <= 1.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. count distinguishes full from empty.
- P holds its last popped value until the next successful pop, clear or reset.
- head = mem[rptr] when not empty, otherwise 0. Purely combinational.
- Sticky flags stay set until clear or reset.

Decomposition:
- Package branch_fifo_pkg holds:
  - BFIFO_WIDTH_DEF=11 and BFIFO_DEPTH_DEF=4.
  - A function computing the pointer width.
  - An enum for the push-source select, SRC_I1 and SRC_I2.
- One sub-module is natural: bfifo_ptr_ctrl.
  - Contains the pointers, count, full/empty and sticky flags.
  - Outputs are wr_en, rd_en, wptr and rptr.
- The top level holds the source mux, the storage array and the P register.

Test Plan:
- Assert reset mid-stream with count=3 -> next cycle count=0, empty=1, P=0, flags=0. State stays unchanged while reset is held.
- DEPTH=4: push 0x101, 0x202 (enable=1, select=0 so I2 is pushed), then 0x303, 0x404 -> full=1. Pop 4 times -> P sequence 0x101, 0x202, 0x303, 0x404; empty=1.
- enable=0, select=0, I1=0x7FF, I2=0x001, push -> head=0x7FF.
- When full: push alone -> overflow=1, count=4. Push+pop together -> count=4, oldest entry on P, overflow unchanged.
- When empty: pop -> underflow=1, P unchanged. Push+pop with I1=0x055 -> count=1, head=0x055, P unchanged.
- Six push/pop pairs across the pointer wrap -> FIFO order preserved. Then clear with push=1 -> count=0, flags=0, P=0.

Source files
------------

// File: rtl/branch_fifo_pkg.sv
// Shared definitions for the branch backup FIFO: default geometry,
// pointer-width helper and the push-source select encoding.
package branch_fifo_pkg;

  localparam int BFIFO_WIDTH_DEF = 11;
  localparam int BFIFO_DEPTH_DEF = 4;

  // Pointer width for a power-of-two depth; never narrower than one bit.
  function automatic int bfifo_ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Which candidate bus feeds the push data.
  typedef enum logic {
    SRC_I1 = 1'b0,
    SRC_I2 = 1'b1
  } bfifo_src_e;

endpackage

// File: rtl/bfifo_ptr_ctrl.sv
// Pointer, occupancy and sticky-flag bookkeeping for the branch backup FIFO.
// Decides which pushes/pops are honoured and hands write/read strobes and
// addresses to the storage in the top level.
module bfifo_ptr_ctrl
  import branch_fifo_pkg::*;
#(
  parameter int DEPTH = BFIFO_DEPTH_DEF,
  parameter int CNT_W = $clog2(DEPTH) + 1,
  parameter int PTR_W = bfifo_ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  output logic             wr_en,
  output logic             rd_en,
  output logic [PTR_W-1:0] wptr,
  output logic [PTR_W-1:0] rptr,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_empty;
  logic             w_full;
  logic             w_wr;
  logic             w_rd;
  logic             w_ovf_evt;
  logic             w_udf_evt;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));

  // Accept/reject decisions: a full FIFO still takes a push when a pop frees
  // a slot in the same cycle; a pop on empty never bypasses a same-cycle push.
  always_comb begin
    w_wr      = 1'b0;
    w_rd      = 1'b0;
    w_ovf_evt = 1'b0;
    w_udf_evt = 1'b0;
    if (!clear) begin
      w_rd      = pop && !w_empty;
      w_udf_evt = pop && w_empty;
      w_wr      = push && (!w_full || pop);
      w_ovf_evt = push && w_full && !pop;
    end
  end

  // Pointer/count/flag state; clear outranks any same-cycle push or pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clear) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + PTR_W'(1);
      if (w_rd) r_rptr <= r_rptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_wr) - CNT_W'(w_rd);
      if (w_ovf_evt) r_overflow <= 1'b1;
      if (w_udf_evt) r_underflow <= 1'b1;
    end
  end

  assign wr_en     = w_wr;
  assign rd_en     = w_rd;
  assign wptr      = r_wptr;
  assign rptr      = r_rptr;
  assign count     = r_count;
  assign empty     = w_empty;
  assign full      = w_full;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: rtl/branch_backup_fifo.sv
// Branch backup FIFO: stores the non-predicted-path PC for each predicted
// branch and returns it, oldest first, when recovery pops on a mispredict.
module branch_backup_fifo
  import branch_fifo_pkg::*;
#(
  parameter int WIDTH = BFIFO_WIDTH_DEF,
  parameter int DEPTH = BFIFO_DEPTH_DEF,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic             select,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] I1,
  input  logic [WIDTH-1:0] I2,
  output logic [WIDTH-1:0] P,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int PTR_W = bfifo_ptr_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_p;

  bfifo_src_e       w_src;
  logic [WIDTH-1:0] w_curr;
  logic             w_wr_en;
  logic             w_rd_en;
  logic [PTR_W-1:0] w_wptr;
  logic [PTR_W-1:0] w_rptr;
  logic             w_empty;

  // Source selection: I2 only when select is honoured and low, else I1.
  always_comb begin
    w_src  = (enable && !select) ? SRC_I2 : SRC_I1;
    w_curr = (w_src == SRC_I2) ? I2 : I1;
  end

  bfifo_ptr_ctrl #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W),
    .PTR_W (PTR_W)
  ) u_ptr_ctrl (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .push      (push),
    .pop       (pop),
    .wr_en     (w_wr_en),
    .rd_en     (w_rd_en),
    .wptr      (w_wptr),
    .rptr      (w_rptr),
    .count     (count),
    .empty     (w_empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // Storage array; contents need no reset because head masks empty slots.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wptr] <= w_curr;
  end

  // Pop data register; holds the last popped PC until the next pop/clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_p <= '0;
    end else if (clear) begin
      r_p <= '0;
    end else if (w_rd_en) begin
      r_p <= r_mem[w_rptr];
    end
  end

  assign P     = r_p;
  assign head  = w_empty ? '0 : r_mem[w_rptr];
  assign empty = w_empty;

endmodule

// File: tb/tb_branch_backup_fifo.sv
// Self-checking bench for branch_backup_fifo: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_branch_backup_fifo;

  localparam int WIDTH = 11;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             clear;
  logic             enable;
  logic             select;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] I1;
  logic [WIDTH-1:0] I2;
  logic [WIDTH-1:0] P;
  logic [WIDTH-1:0] head;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] mQ[$];
  logic [WIDTH-1:0] mP;
  logic             mOvf;
  logic             mUdf;

  branch_backup_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .enable    (enable),
    .select    (select),
    .push      (push),
    .pop       (pop),
    .I1        (I1),
    .I2        (I2),
    .P         (P),
    .head      (head),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic compare(input string tag, input string name,
                         input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("[TB] FAIL %s.%s observed=%0h expected=%0h", tag, name, obs, exp);
      $error("[TB] %s.%s observed=%0h expected=%0h", tag, name, obs, exp);
    end
  endtask

  // Compare every DUT output against the reference model.
  task automatic checkOutput(input string tag);
    logic [WIDTH-1:0] expHead;
    int               n;
    n       = mQ.size();
    expHead = (n > 0) ? mQ[0] : '0;
    compare(tag, "count", 32'(count), 32'(n));
    compare(tag, "empty", 32'(empty), 32'(n == 0));
    compare(tag, "full", 32'(full), 32'(n == DEPTH));
    compare(tag, "head", 32'(head), 32'(expHead));
    compare(tag, "P", 32'(P), 32'(mP));
    compare(tag, "overflow", 32'(overflow), 32'(mOvf));
    compare(tag, "underflow", 32'(underflow), 32'(mUdf));
  endtask

  task automatic modelReset();
    mQ.delete();
    mP   = '0;
    mOvf = 1'b0;
    mUdf = 1'b0;
  endtask

  // Reference behaviour for one clock edge, expressed as queue operations:
  // the pop is resolved first so a full FIFO can still accept the push.
  task automatic modelEdge(input logic iPush, iPop, iClear, iEn, iSel,
                           input logic [WIDTH-1:0] iI1, iI2);
    logic [WIDTH-1:0] curr;
    if (iClear) begin
      modelReset();
    end else begin
      curr = (iEn && !iSel) ? iI2 : iI1;
      if (iPop) begin
        if (mQ.size() > 0) mP = mQ.pop_front();
        else               mUdf = 1'b1;
      end
      if (iPush) begin
        if (mQ.size() < DEPTH) mQ.push_back(curr);
        else                   mOvf = 1'b1;
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, update the model and check.
  task automatic applyStimulus(input logic iPush, iPop, iClear, iEn, iSel,
                               input logic [WIDTH-1:0] iI1, iI2,
                               input string tag);
    push   = iPush;
    pop    = iPop;
    clear  = iClear;
    enable = iEn;
    select = iSel;
    I1     = iI1;
    I2     = iI2;
    @(posedge clk);
    modelEdge(iPush, iPop, iClear, iEn, iSel, iI1, iI2);
    #1;
    checkOutput(tag);
  endtask

  function automatic logic [WIDTH-1:0] rnd();
    return WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
  endfunction

  initial begin
    reset  = 1'b1;
    clear  = 1'b0;
    enable = 1'b0;
    select = 1'b0;
    push   = 1'b0;
    pop    = 1'b0;
    I1     = '0;
    I2     = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset");
    @(negedge clk);
    reset = 1'b0;

    // Fill through both sources, then drain in order.
    applyStimulus(1, 0, 0, 1, 0, rnd(), 11'h101, "fill0");
    applyStimulus(1, 0, 0, 1, 0, rnd(), 11'h202, "fill1");
    applyStimulus(1, 0, 0, 1, 1, 11'h303, rnd(), "fill2");
    applyStimulus(1, 0, 0, 0, 0, 11'h404, rnd(), "fill3");
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 1, 0, 1, 1, rnd(), rnd(), $sformatf("drain%0d", i));

    // enable=0 forces I1 regardless of select.
    applyStimulus(1, 0, 0, 0, 0, 11'h7FF, 11'h001, "forceI1");
    applyStimulus(0, 1, 0, 0, 0, rnd(), rnd(), "forceI1pop");

    // Full: lone push overflows, push+pop is accepted.
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 0, 0, 0, 0, rnd(), rnd(), $sformatf("refill%0d", i));
    applyStimulus(1, 0, 0, 0, 0, rnd(), rnd(), "ovfPush");
    applyStimulus(1, 1, 0, 0, 0, rnd(), rnd(), "fullPushPop");

    // Empty: pop underflows, push+pop accepts the push only.
    applyStimulus(0, 0, 1, 0, 0, rnd(), rnd(), "clear1");
    applyStimulus(1, 0, 0, 1, 1, 11'h0AA, rnd(), "seedP");
    applyStimulus(0, 1, 0, 1, 1, rnd(), rnd(), "popSeed");
    applyStimulus(0, 1, 0, 1, 1, rnd(), rnd(), "udfPop");
    applyStimulus(1, 1, 0, 0, 1, 11'h055, rnd(), "emptyPushPop");

    // Push/pop pairs walking the pointers past the wrap point.
    applyStimulus(1, 0, 0, 0, 0, rnd(), rnd(), "wrapPre");
    for (int i = 0; i < 6; i++)
      applyStimulus(1, 1, 0, 1, $urandom_range(0, 1), rnd(), rnd(),
                    $sformatf("wrap%0d", i));

    // Asynchronous reset mid-stream with three entries held.
    applyStimulus(0, 1, 0, 0, 0, rnd(), rnd(), "preRst0");
    applyStimulus(1, 0, 0, 0, 0, rnd(), rnd(), "preRst1");
    applyStimulus(1, 0, 0, 0, 0, rnd(), rnd(), "preRst2");
    compare("preRst", "count3", 32'(count), 32'd3);
    push  = 1'b1;
    pop   = 1'b1;
    reset = 1'b1;
    modelReset();
    #1;
    checkOutput("rstAsync");
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstHeld");
    @(negedge clk);
    reset = 1'b0;

    // Clear outranks a same-cycle push.
    applyStimulus(1, 0, 0, 0, 0, rnd(), rnd(), "preClr0");
    applyStimulus(0, 1, 0, 0, 0, rnd(), rnd(), "preClr1");
    applyStimulus(0, 1, 0, 0, 0, rnd(), rnd(), "preClr2");
    applyStimulus(1, 0, 1, 0, 0, rnd(), rnd(), "clearPush");

    // Random traffic with occasional clears.
    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 1), $urandom_range(0, 1),
                    ($urandom_range(0, 31) == 0), $urandom_range(0, 1),
                    $urandom_range(0, 1), rnd(), rnd(),
                    $sformatf("rand%0d", i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
